btn_sw_conditioner: RTL and testbench
=====================================

Name: btn_sw_conditioner

Overview:
- Input-conditioning stage directly upstream of the lab's JK-flip-flop sequential circuit.
- Takes raw, asynchronous board inputs: push-button BTN0 and slide switch SW0.
- Produces for the downstream circuit:
  - a clean synchronized switch level;
  - a debounced button level;
  - a single-clock press pulse, used as the step/clock-enable for the state machine.
- One instance per board; all outputs are registered.

Parameters:
- SYNC_STAGES, 2: synchronizer flip-flops per raw input; legal range 2..4.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); minimum 1.
- REPEAT_DELAY, 25000000: cycles held before the first auto-repeat pulse. Used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 10000000: cycles between subsequent auto-repeat pulses. Used only with AUTO_REPEAT_EN.

Ports:
- CLK  input  1  system clock, all logic rising-edge.
- RST  input  1  asynchronous, active-high reset.
- BTN_RAW  input  1  raw push-button, active-high, bouncy, asynchronous.
- SW_RAW  input  1  raw slide switch, bouncy, asynchronous.
- BTN_LEVEL  output  1  debounced button level.
- BTN_PULSE  output  1  one-cycle pulse per accepted press (and per repeat, if enabled).
- SW_LEVEL  output  1  debounced switch level.

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high. All flops clear immediately on RST=1, independent of CLK.
- Reset values:
  - BTN_LEVEL=0, BTN_PULSE=0, SW_LEVEL=0;
  - synchronizer chains all 0;
  - counters 0;
  - button FSM in IDLE.
- Synchronizer: each raw input passes through SYNC_STAGES flops; s_btn and s_sw are the final-stage outputs.
- Counter: width = clog2(DEBOUNCE_CYCLES+1); it never wraps.
- Button FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: s_btn=1 -> PRESS_WAIT, counter cleared to 1.
  - PRESS_WAIT:
    - s_btn=0 -> IDLE (bounce rejected, no pulse).
    - s_btn=1 and counter==DEBOUNCE_CYCLES -> PRESSED; BTN_LEVEL<=1 and BTN_PULSE<=1 for exactly one cycle.
    - Otherwise counter increments.
  - PRESSED: s_btn=0 -> RELEASE_WAIT, counter=1. BTN_PULSE<=0 in every cycle unless an auto-repeat fires.
  - RELEASE_WAIT:
    - s_btn=1 -> PRESSED (release bounce rejected, no new pulse).
    - s_btn=0 and counter==DEBOUNCE_CYCLES -> IDLE; BTN_LEVEL<=0.
    - Otherwise counter increments.
- Latency: raw 0->1 held stable produces BTN_PULSE high exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks after the first sampling edge. Release latency to BTN_LEVEL=0 is the same figure.
- Release: no pulse is ever generated on release.
- Minimum press/release: pulses shorter than DEBOUNCE_CYCLES after synchronization produce no output change.
- Switch path: same debounce rule, level only (two-state: stable-low / stable-high with pending counter). SW_LEVEL changes after SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks of stable input. There is no pulse output for the switch.
- Simultaneous changes: button and switch paths are fully independent; changes on both in the same cycle are each handled per their own counter.
- Reset mid-operation: any pending count is discarded.
  - A button held through reset deassertion is treated as a new press: one pulse after full debounce.
  - A switch high through reset is reported high after full debounce.
- Sizing: DEBOUNCE_CYCLES=1 is legal (one stable cycle suffices).

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter runs.
  - BTN_PULSE fires one cycle after REPEAT_DELAY held cycles, then every REPEAT_PERIOD cycles while still in PRESSED.
  - Entering RELEASE_WAIT clears the repeat counter; returning to PRESSED from RELEASE_WAIT restarts the delay.
  - BTN_LEVEL is unaffected.
- Undefined: exactly one pulse per press; no repeat counter or logic is synthesized.

Decomposition:
- Shared package/header lab9_pkg holds:
  - button FSM state encodings (IDLE=2'b00, PRESS_WAIT=2'b01, PRESSED=2'b11, RELEASE_WAIT=2'b10);
  - default constants DEBOUNCE_CYCLES and SYNC_STAGES.
- One sub-module: sync_debounce_cell (synchronizer + stable-count level filter, parameterized). It is instantiated for SW_RAW directly and for BTN_RAW's synchronizer. The top keeps the button FSM, pulse and optional repeat logic.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Clean press: BTN_RAW 0->1 held 20 cycles -> BTN_PULSE high exactly once, 7 clocks after first sampling edge; BTN_LEVEL stays 1.
- Bounce rejection: BTN_RAW toggles 1,0,1,0 each 2 cycles, then steady 1 -> exactly one pulse, 7 clocks after the steady 1 begins; no pulse during toggling.
- Release: held button released with 3-cycle bounce, then steady 0 -> BTN_LEVEL falls 7 clocks after steady 0; BTN_PULSE never asserted.
- Switch: SW_RAW 0->1 with 1-cycle glitch to 0 at cycle 3, then steady -> SW_LEVEL rises 7 clocks after the glitch ends; a 3-cycle SW_RAW high pulse alone -> SW_LEVEL stays 0.
- Reset mid-debounce: RST asserted asynchronously during PRESS_WAIT with button held -> all outputs 0 immediately; after deassert, pulse arrives 7 clocks later.
- Auto-repeat (BTN_AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5): hold 40 cycles -> initial pulse, then pulses at +10, +15, +20, ... until release.

Source files
------------

// File: rtl/lab9_pkg.sv
// Shared encodings and default sizing for the BTN0/SW0 input-conditioning stage.
package lab9_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b11,
    RELEASE_WAIT = 2'b10
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_SYNC_STAGES     = 2;

endpackage

// File: rtl/sync_debounce_cell.sv
// Raw-input synchronizer with an optional stable-count level filter.
// FILTER_EN=0 gives the bare synchronized signal.
module sync_debounce_cell
  import lab9_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit FILTER_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic s;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  if (FILTER_EN) begin : g_filt
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    // Any cycle agreeing with the current level discards the pending count.
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (s != level_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES)) level_d = s;
        else                               cnt_d   = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    assign dout = level_q;
  end else begin : g_nofilt
    assign dout = s;
  end

endmodule

// File: rtl/btn_sw_conditioner.sv
// BTN0/SW0 conditioner: synchronized, debounced levels plus a one-cycle press pulse.
// Define BTN_AUTO_REPEAT_EN to add hold-to-repeat pulses on the button.
module btn_sw_conditioner
  import lab9_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_RAW,
  input  logic SW_RAW,
  output logic BTN_LEVEL,
  output logic BTN_PULSE,
  output logic SW_LEVEL
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("btn_sw_conditioner: illegal parameter value");
  end

  logic s_btn;

  sync_debounce_cell #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .FILTER_EN(1'b1)
  ) u_sw (
    .clk(CLK), .rst(RST), .din(SW_RAW), .dout(SW_LEVEL)
  );

  sync_debounce_cell #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .FILTER_EN(1'b0)
  ) u_btn_sync (
    .clk(CLK), .rst(RST), .din(BTN_RAW), .dout(s_btn)
  );

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          pulse_q, pulse_d;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_tgt;
  logic          rpt_first_q, rpt_first_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    pulse_d = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    // Repeat timer only survives consecutive held cycles in PRESSED.
    rpt_cnt_d   = '0;
    rpt_first_d = 1'b1;
    rpt_tgt     = rpt_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
`endif
    case (state_q)
      IDLE: if (s_btn) begin
        state_d = PRESS_WAIT;
        cnt_d   = CW'(1);
      end
      PRESS_WAIT: begin
        if (!s_btn) state_d = IDLE;
        else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
          state_d = PRESSED;
          lvl_d   = 1'b1;
          pulse_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      PRESSED: begin
        if (!s_btn) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end
`ifdef BTN_AUTO_REPEAT_EN
        else if (rpt_cnt_q == rpt_tgt) begin
          pulse_d     = 1'b1;
          rpt_first_d = 1'b0;
        end else begin
          rpt_cnt_d   = rpt_cnt_q + 1'b1;
          rpt_first_d = rpt_first_q;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (s_btn) state_d = PRESSED;
        else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
          state_d = IDLE;
          lvl_d   = 1'b0;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      pulse_q <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
`endif
    end
  end

  assign BTN_LEVEL = lvl_q;
  assign BTN_PULSE = pulse_q;

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Directed bench for btn_sw_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_btn_sw_conditioner;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic BTN_RAW = 1'b0;
  logic SW_RAW = 1'b0;
  logic BTN_LEVEL, BTN_PULSE, SW_LEVEL;

  int n_tests = 0;
  int n_fail  = 0;

  int   pc;
  int   p_at [8];
  int   bl_at, sl_at;
  logic bl0, sl0;

  btn_sw_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN_RAW(BTN_RAW), .SW_RAW(SW_RAW),
    .BTN_LEVEL(BTN_LEVEL), .BTN_PULSE(BTN_PULSE), .SW_LEVEL(SW_LEVEL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs n edges, logging pulse positions and the first edge at which each level moves.
  task automatic run(input int n);
    pc = 0;
    for (int k = 0; k < 8; k++) p_at[k] = 0;
    bl_at = 0;
    sl_at = 0;
    bl0 = BTN_LEVEL;
    sl0 = SW_LEVEL;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (BTN_PULSE === 1'b1) begin
        if (pc < 8) p_at[pc] = i;
        pc++;
      end
      if (bl_at == 0 && BTN_LEVEL !== bl0) bl_at = i;
      if (sl_at == 0 && SW_LEVEL !== sl0) sl_at = i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 RST = 1'b1;
    #1;
    chk("reset_btn_level", 32'(BTN_LEVEL), 0);
    chk("reset_btn_pulse", 32'(BTN_PULSE), 0);
    chk("reset_sw_level",  32'(SW_LEVEL),  0);
    tick(); tick();
    RST = 1'b0;

    // Clean press
    BTN_RAW = 1'b1;
    run(20);
    chk("press_pulse_count", pc, 1);
    chk("press_pulse_at",    p_at[0], 7);
    chk("press_level_at",    bl_at, 7);
    chk("press_level_held",  32'(BTN_LEVEL), 1);

    // Release with bounce 0,1,1 then steady 0
    BTN_RAW = 1'b0; tick();
    BTN_RAW = 1'b1; tick(); tick();
    BTN_RAW = 1'b0;
    run(20);
    chk("release_level_at", bl_at, 7);
    chk("release_no_pulse", pc, 0);
    chk("release_level",    32'(BTN_LEVEL), 0);

    // Press bounce 1,1,0,0,1,1,0,0 then steady 1
    for (int k = 0; k < 4; k++) begin
      BTN_RAW = (k % 2 == 0);
      run(2);
      chk("bounce_no_pulse", pc, 0);
    end
    BTN_RAW = 1'b1;
    run(20);
    chk("bounce_pulse_count", pc, 1);
    chk("bounce_pulse_at",    p_at[0], 7);

    BTN_RAW = 1'b0;
    run(20);
    chk("release2_level_at", bl_at, 7);

    // Switch rise with a one-cycle glitch
    SW_RAW = 1'b1;
    run(2);
    chk("sw_glitch_hold", sl_at, 0);
    SW_RAW = 1'b0;
    run(1);
    SW_RAW = 1'b1;
    run(20);
    chk("sw_rise_at",     sl_at, 7);
    chk("sw_level_high",  32'(SW_LEVEL), 1);
    chk("sw_no_btn_pulse", pc, 0);

    // Switch fall, then a 3-cycle high pulse that must be filtered
    SW_RAW = 1'b0;
    run(20);
    chk("sw_fall_at", sl_at, 7);
    SW_RAW = 1'b1;
    run(3);
    chk("sw_short_a", sl_at, 0);
    SW_RAW = 1'b0;
    run(20);
    chk("sw_short_b", sl_at, 0);
    chk("sw_short_level", 32'(SW_LEVEL), 0);

    // Simultaneous change on both inputs
    BTN_RAW = 1'b1;
    SW_RAW  = 1'b1;
    run(10);
    chk("simul_pulse_at",  p_at[0], 7);
    chk("simul_pulse_cnt", pc, 1);
    chk("simul_sw_at",     sl_at, 7);

    // Asynchronous reset with both levels high, inputs held through it
    #2 RST = 1'b1;
    #1;
    chk("async_rst_btn_level", 32'(BTN_LEVEL), 0);
    chk("async_rst_sw_level",  32'(SW_LEVEL),  0);
    chk("async_rst_btn_pulse", 32'(BTN_PULSE), 0);
    tick(); tick();
    RST = 1'b0;
    run(12);
    chk("held_rst_pulse_at",  p_at[0], 7);
    chk("held_rst_pulse_cnt", pc, 1);
    chk("held_rst_sw_at",     sl_at, 7);

    // Reset during PRESS_WAIT
    BTN_RAW = 1'b0;
    SW_RAW  = 1'b0;
    run(20);
    BTN_RAW = 1'b1;
    run(4);
    chk("pw_no_pulse_yet", pc, 0);
    #2 RST = 1'b1;
    #1;
    chk("pw_rst_btn_level", 32'(BTN_LEVEL), 0);
    tick();
    RST = 1'b0;
    run(12);
    chk("pw_rst_pulse_at",  p_at[0], 7);
    chk("pw_rst_pulse_cnt", pc, 1);

    // Long hold: single pulse, or repeats at +10 then every +5
    BTN_RAW = 1'b0;
    run(20);
    BTN_RAW = 1'b1;
    run(40);
    chk("hold_first_at", p_at[0], 7);
`ifdef BTN_AUTO_REPEAT_EN
    chk("hold_pulse_cnt", pc, 6);
    chk("hold_rpt1_at",   p_at[1], 17);
    chk("hold_rpt2_at",   p_at[2], 22);
    chk("hold_rpt3_at",   p_at[3], 27);
`else
    chk("hold_pulse_cnt", pc, 1);
`endif
    chk("hold_level", 32'(BTN_LEVEL), 1);
    BTN_RAW = 1'b0;
    run(20);
    chk("hold_release_at", bl_at, 7);
    chk("hold_release_no_pulse", pc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
